// File: rtl/crt_line_buf_ctl_pkg.sv
// Shared types for the CRT line-buffer controller: per-buffer state encoding
// and the A/B buffer-select constants.
package crt_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } buf_state_t;

    localparam logic BUF_A = 1'b0;
    localparam logic BUF_B = 1'b1;

endpackage

// File: rtl/crt_line_buf_ctl_buf_state.sv
// State register for one CRT line buffer. Instantiated once for A, once for B.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   EMPTY    | no valid data, may be picked for the next fill
//   FILLING  | memory data is being written into this buffer
//   FULL     | all words written, display has not started
//   DRAINING | display is popping words out of this buffer
module crt_buf_state
    import crt_buf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       fill_start,
    input  logic       fill_last,
    input  logic       pop_first,
    input  logic       pop_last,
    input  logic       flush,
    output buf_state_t state
);

    buf_state_t state_q;
    buf_state_t state_d;

    // Next-state: normal fill/drain progression, flush overrides to EMPTY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:    if (fill_start) state_d = FILLING;
            FILLING:  if (fill_last)  state_d = FULL;
            FULL: begin
                if (pop_last)       state_d = EMPTY;
                else if (pop_first) state_d = DRAINING;
            end
            DRAINING: if (pop_last)   state_d = EMPTY;
            default:                  state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/crt_line_buf_ctl.sv
// CRT line-fetch buffer controller: requests fills from the memory arbiter,
// generates write addresses for returning data, and drains buffers A/B in
// ping-pong order toward the display.
// Optional build macro CRT_UNDERRUN_CNT_EN adds a saturating underrun counter.
module crt_line_buf_ctl
    import crt_buf_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          mem_clk,
    input  logic          hreset,
    input  logic          crt_gnt,
    input  logic          mem_data_valid,
    input  logic          sync_crt_line_end,
    input  logic          crt_pop,
    output logic          crt_req,
    output logic          a_empty,
    output logic          b_empty,
    output logic          a_full_done,
    output logic          b_full_done,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_addr,
    output logic          rd_sel,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic          underrun
`ifdef CRT_UNDERRUN_CNT_EN
   ,output logic [15:0]   underrun_cnt
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    buf_state_t    st_a, st_b, rd_state;
    logic          live, filling, fill_go, fill_last;
    logic          pop_ok, pop_first, pop_last;
    logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic          rd_valid_q;

    // Line end and reset both silence every pulse output for that cycle.
    assign live      = ~hreset & ~sync_crt_line_end;
    assign a_empty   = (st_a == EMPTY);
    assign b_empty   = (st_b == EMPTY);
    assign filling   = (st_a == FILLING) | (st_b == FILLING);
    assign crt_req   = (a_empty | b_empty) & ~filling & live;
    assign fill_go   = crt_gnt & ~filling & (a_empty | b_empty) & live;
    assign wr_en     = mem_data_valid & filling & live;
    assign fill_last = wr_en & (wr_addr_q == LAST_ADDR);

    assign a_full_done = fill_last & (wr_sel_q == BUF_A);
    assign b_full_done = fill_last & (wr_sel_q == BUF_B);

    assign rd_state  = (rd_sel_q == BUF_B) ? st_b : st_a;
    assign pop_ok    = crt_pop & live & ((rd_state == FULL) | (rd_state == DRAINING));
    assign pop_first = pop_ok & (rd_state == FULL);
    assign pop_last  = pop_ok & (rd_addr_q == LAST_ADDR);
    assign underrun  = crt_pop & live & ~pop_ok;

    crt_buf_state u_buf_a (
        .clk        (mem_clk),
        .rst        (hreset),
        .fill_start (fill_go & a_empty),
        .fill_last  (fill_last & (wr_sel_q == BUF_A)),
        .pop_first  (pop_first & (rd_sel_q == BUF_A)),
        .pop_last   (pop_last & (rd_sel_q == BUF_A)),
        .flush      (sync_crt_line_end),
        .state      (st_a)
    );

    // fill_go already implies one buffer is empty, so ~a_empty selects B.
    crt_buf_state u_buf_b (
        .clk        (mem_clk),
        .rst        (hreset),
        .fill_start (fill_go & ~a_empty),
        .fill_last  (fill_last & (wr_sel_q == BUF_B)),
        .pop_first  (pop_first & (rd_sel_q == BUF_B)),
        .pop_last   (pop_last & (rd_sel_q == BUF_B)),
        .flush      (sync_crt_line_end),
        .state      (st_b)
    );

    // Address/select next-state: fill start clears the write pointer, accepted
    // writes and pops advance their pointers, line end rewinds everything.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_sel_d  = wr_sel_q;
        rd_addr_d = rd_addr_q;
        rd_sel_d  = rd_sel_q;
        if (fill_go) begin
            wr_sel_d  = a_empty ? BUF_A : BUF_B;
            wr_addr_d = '0;
        end else if (wr_en) begin
            wr_addr_d = wr_addr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_addr_d = rd_addr_q + AW'(1);
            if (pop_last) rd_sel_d = ~rd_sel_q;
        end
        if (sync_crt_line_end) begin
            wr_addr_d = '0;
            rd_addr_d = '0;
            rd_sel_d  = BUF_A;
        end
    end

    // Pointer, select and read-valid registers.
    always_ff @(posedge mem_clk) begin
        if (hreset) begin
            wr_addr_q  <= '0;
            wr_sel_q   <= BUF_A;
            rd_addr_q  <= '0;
            rd_sel_q   <= BUF_A;
            rd_valid_q <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            wr_sel_q   <= wr_sel_d;
            rd_addr_q  <= rd_addr_d;
            rd_sel_q   <= rd_sel_d;
            rd_valid_q <= pop_ok;
        end
    end

    assign wr_addr  = wr_addr_q;
    assign wr_sel   = wr_sel_q;
    assign rd_addr  = rd_addr_q;
    assign rd_sel   = rd_sel_q;
    assign rd_valid = rd_valid_q;

`ifdef CRT_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    // Saturating underrun counter; only hreset clears it.
    always_ff @(posedge mem_clk) begin
        if (hreset)                            ucnt_q <= 16'd0;
        else if (underrun && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_crt_line_buf_ctl.sv
// Directed bench for crt_line_buf_ctl with DEPTH=4.
module tb_crt_line_buf_ctl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          mem_clk = 1'b0;
    logic          hreset, crt_gnt, mem_data_valid, sync_crt_line_end, crt_pop;
    logic          crt_req, a_empty, b_empty, a_full_done, b_full_done;
    logic          wr_en, wr_sel, rd_sel, rd_valid, underrun;
    logic [AW-1:0] wr_addr, rd_addr;
`ifdef CRT_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    crt_line_buf_ctl #(.DEPTH(DEPTH)) dut (
        .mem_clk           (mem_clk),
        .hreset            (hreset),
        .crt_gnt           (crt_gnt),
        .mem_data_valid    (mem_data_valid),
        .sync_crt_line_end (sync_crt_line_end),
        .crt_pop           (crt_pop),
        .crt_req           (crt_req),
        .a_empty           (a_empty),
        .b_empty           (b_empty),
        .a_full_done       (a_full_done),
        .b_full_done       (b_full_done),
        .wr_en             (wr_en),
        .wr_sel            (wr_sel),
        .wr_addr           (wr_addr),
        .rd_sel            (rd_sel),
        .rd_addr           (rd_addr),
        .rd_valid          (rd_valid),
        .underrun          (underrun)
`ifdef CRT_UNDERRUN_CNT_EN
       ,.underrun_cnt      (underrun_cnt)
`endif
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hreset = 1'b1; crt_gnt = 1'b0; mem_data_valid = 1'b0;
        sync_crt_line_end = 1'b0; crt_pop = 1'b0;
        tick(); tick();
        #1;
        chk("rst_a_empty", a_empty, 1);
        chk("rst_b_empty", b_empty, 1);
        chk("rst_crt_req", crt_req, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_sels", {wr_sel, rd_sel}, 0);

        // idle after reset
        hreset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_req", crt_req, 1);
            chk("idle_empty", {a_empty, b_empty}, 2'b11);
            chk("idle_act", {wr_en, underrun, rd_valid, a_full_done, b_full_done}, 0);
            tick();
        end

        // fill A
        crt_gnt = 1'b1; #1;
        chk("req_before_gnt", crt_req, 1);
        tick();
        crt_gnt = 1'b0; #1;
        chk("fillA_wr_sel", wr_sel, 0);
        chk("fillA_a_empty", a_empty, 0);
        chk("fillA_req", crt_req, 0);
        mem_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fillA_wr_en", wr_en, 1);
            chk("fillA_wr_addr", wr_addr, i);
            chk("fillA_a_done", a_full_done, (i == 3) ? 1 : 0);
            chk("fillA_b_done", b_full_done, 0);
            tick();
        end
        mem_data_valid = 1'b0; #1;
        chk("fillA_end_empty", {a_empty, b_empty}, 2'b01);
        chk("fillA_end_req", crt_req, 1);
        chk("fillA_wrap", wr_addr, 0);
        // valid while not filling is ignored
        mem_data_valid = 1'b1; #1;
        chk("stray_valid_wr_en", wr_en, 0);
        tick();
        mem_data_valid = 1'b0; #1;
        chk("stray_valid_addr", wr_addr, 0);

        // fill B
        crt_gnt = 1'b1; tick();
        crt_gnt = 1'b0; #1;
        chk("fillB_wr_sel", wr_sel, 1);
        chk("fillB_b_empty", b_empty, 0);
        mem_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fillB_wr_addr", wr_addr, i);
            chk("fillB_b_done", b_full_done, (i == 3) ? 1 : 0);
            chk("fillB_a_done", a_full_done, 0);
            tick();
        end
        mem_data_valid = 1'b0; #1;
        chk("both_full_req", crt_req, 0);
        chk("both_full_empty", {a_empty, b_empty}, 0);

        // 8 back-to-back pops
        crt_pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_rd_sel", rd_sel, i / 4);
            chk("drain_rd_addr", rd_addr, i % 4);
            chk("drain_rd_valid", rd_valid, (i > 0) ? 1 : 0);
            chk("drain_underrun", underrun, 0);
            chk("drain_a_empty", a_empty, (i >= 4) ? 1 : 0);
            tick();
        end
        crt_pop = 1'b0; #1;
        chk("drain_last_valid", rd_valid, 1);
        chk("drain_b_empty", b_empty, 1);
        chk("drain_rd_sel_wrap", rd_sel, 0);
        chk("drain_rd_addr_wrap", rd_addr, 0);
        tick(); #1;
        chk("drain_valid_off", rd_valid, 0);

        // underrun while A filling; grant held high during fill
        crt_gnt = 1'b1; tick();
        mem_data_valid = 1'b1; #1;
        chk("gnt_held_addr0", wr_addr, 0);
        tick(); tick();
        crt_gnt = 1'b0; mem_data_valid = 1'b0; crt_pop = 1'b1; #1;
        chk("ur_wr_addr", wr_addr, 2);
        chk("ur_pulse", underrun, 1);
        tick();
        crt_pop = 1'b0; #1;
        chk("ur_rd_addr", rd_addr, 0);
        chk("ur_rd_valid", rd_valid, 0);
        chk("ur_wr_addr_kept", wr_addr, 2);
        chk("ur_pulse_off", underrun, 0);
`ifdef CRT_UNDERRUN_CNT_EN
        chk("ur_cnt1", underrun_cnt, 1);
`endif
        mem_data_valid = 1'b1; tick();
        // last write and pop of same buffer together
        crt_pop = 1'b1; #1;
        chk("lastwr_pop_done", a_full_done, 1);
        chk("lastwr_pop_ur", underrun, 1);
        tick();
        mem_data_valid = 1'b0; crt_pop = 1'b0; #1;
        chk("lastwr_pop_a_full", a_empty, 0);
        chk("lastwr_pop_req", crt_req, 1);
        chk("lastwr_pop_rd_addr", rd_addr, 0);

        // line end mid-fill of B with A draining
        crt_gnt = 1'b1; tick();
        crt_gnt = 1'b0; mem_data_valid = 1'b1; crt_pop = 1'b1; #1;
        chk("le_wr_sel", wr_sel, 1);
        chk("le_pop_ok", underrun, 0);
        chk("le_wr_en", wr_en, 1);
        tick();
        mem_data_valid = 1'b0; #1;
        chk("le_rd_valid_pre", rd_valid, 1);
        tick();
        mem_data_valid = 1'b1; sync_crt_line_end = 1'b1; #1;
        chk("le_wr_addr_pre", wr_addr, 1);
        chk("le_rd_addr_pre", rd_addr, 2);
        chk("le_req_forced", crt_req, 0);
        chk("le_suppress", {wr_en, underrun, b_full_done, a_full_done}, 0);
        tick();
        sync_crt_line_end = 1'b0; crt_pop = 1'b0; #1;
        chk("le_empty", {a_empty, b_empty}, 2'b11);
        chk("le_wr_addr", wr_addr, 0);
        chk("le_rd_addr", rd_addr, 0);
        chk("le_rd_sel", rd_sel, 0);
        chk("le_rd_valid", rd_valid, 0);
        chk("le_req", crt_req, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("le_post_valid", {wr_en, b_full_done}, 0);
            tick();
        end
        mem_data_valid = 1'b0; #1;
        chk("le_post_addr", wr_addr, 0);
`ifdef CRT_UNDERRUN_CNT_EN
        chk("le_cnt_kept", underrun_cnt, 2);
`endif

        // reset mid-drain
        crt_gnt = 1'b1; tick();
        crt_gnt = 1'b0; mem_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_data_valid = 1'b0; crt_pop = 1'b1;
        tick(); tick();
        #1;
        chk("rd_mid_addr", rd_addr, 2);
        hreset = 1'b1; #1;
        chk("rst_mid_req", crt_req, 0);
        chk("rst_mid_ur", underrun, 0);
        tick();
        crt_pop = 1'b0; #1;
        chk("rst2_empty", {a_empty, b_empty}, 2'b11);
        chk("rst2_req", crt_req, 0);
        chk("rst2_addrs", {wr_addr, rd_addr}, 0);
        chk("rst2_sels", {wr_sel, rd_sel}, 0);
        chk("rst2_pulses", {rd_valid, wr_en, underrun, a_full_done, b_full_done}, 0);
`ifdef CRT_UNDERRUN_CNT_EN
        chk("rst2_cnt", underrun_cnt, 0);
`endif
        hreset = 1'b0;
`ifdef CRT_UNDERRUN_CNT_EN
        crt_pop = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        crt_pop = 1'b0; #1;
        chk("cnt_saturate", underrun_cnt, 16'hFFFF);
`endif
        #1;
        chk("final_req", crt_req, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crt_line_buf_ctl.md
Name: crt_line_buf_ctl

Overview:
Controls the two CRT line-fetch buffers (A and B) that feed the memory arbiter's CRT path. Raises crt_req when a buffer is empty and picks the buffer to fill when the grant arrives. Generates write addresses for returning memory data and signals a_full_done/b_full_done. On the display side, drains the buffers alternately (ping-pong) and reports a_empty/b_empty. Runs entirely in the mem_clk domain; sync_crt_line_end is already synchronised.

Parameters:
DEPTH, 32, words per buffer; must be a power of two, >= 2
AW, $clog2(DEPTH), address width; localparam derived from DEPTH, not overridable

Ports:
mem_clk  in  1  single clock
hreset  in  1  synchronous reset, active-high
crt_gnt  in  1  CRT grant from the memory arbiter
mem_data_valid  in  1  one fetched word is written this cycle
sync_crt_line_end  in  1  end of active line; flushes both buffers
crt_pop  in  1  display consumer takes one word
crt_req  out  1  request to the arbiter
a_empty  out  1  buffer A empty
b_empty  out  1  buffer B empty
a_full_done  out  1  one-cycle pulse: buffer A fill complete
b_full_done  out  1  one-cycle pulse: buffer B fill complete
wr_en  out  1  buffer RAM write strobe (= mem_data_valid while filling)
wr_sel  out  1  0 = A, 1 = B; buffer being written
wr_addr  out  AW  write word address
rd_sel  out  1  0 = A, 1 = B; buffer being drained
rd_addr  out  AW  read word address
rd_valid  out  1  registered; buffer RAM read data valid one cycle after accepted pop
underrun  out  1  one-cycle pulse: pop while the drain buffer is not ready

Behaviour:
- Each buffer has its own 2-bit state: EMPTY, FILLING, FULL, DRAINING. All registers update on posedge mem_clk.
- Reset (hreset=1): both buffers go to EMPTY; wr_addr=0, rd_addr=0, wr_sel=0, rd_sel=0. All outputs are 0 except a_empty=1 and b_empty=1. Reset wins over every other input.
- Outputs: a_empty = (stateA==EMPTY), b_empty = (stateB==EMPTY). crt_req = (a_empty|b_empty) & ~filling & ~sync_crt_line_end, where filling = a buffer is in FILLING.
- Fill start: on the first cycle crt_gnt=1 while not filling:
  - latch wr_sel = a_empty ? 0 : 1 (A has priority when both are empty);
  - the chosen buffer goes to FILLING next cycle;
  - wr_addr is cleared to 0.
- crt_gnt held high after the fill starts has no further effect.
- Fill: wr_en = mem_data_valid & filling. Each write increments wr_addr. The write at wr_addr==DEPTH-1 does the following:
  - pulses the matching *_full_done the same cycle (combinational from valid);
  - moves the buffer to FULL next cycle;
  - wraps wr_addr to 0.
- mem_data_valid outside FILLING is ignored: no write and no address change.
- Drain: a pop is accepted when the rd_sel buffer is FULL or DRAINING.
  - The buffer moves FULL->DRAINING on the first pop and rd_addr increments.
  - rd_valid=1 the cycle after an accepted pop.
  - The pop at rd_addr==DEPTH-1 moves the buffer to EMPTY, wraps rd_addr to 0 and toggles rd_sel.
- A pop that is not accepted gives underrun=1 for that cycle, with no state change.
- Simultaneous events:
  - The last write into a buffer and a pop of that buffer in the same cycle: the pop is not accepted (the buffer is not yet FULL), so underrun fires.
  - A fill completing in one buffer and a drain completing in the other in the same cycle: both take effect.
  - A fill start and a drain-complete of the other buffer in the same cycle: both take effect; wr_sel uses the pre-update empty flags.
- sync_crt_line_end=1 (priority below reset, above everything else):
  - both buffers go to EMPTY and any fill in progress is aborted;
  - wr_addr=0, rd_addr=0, rd_sel=0;
  - *_full_done, wr_en, rd_valid and underrun are suppressed that cycle;
  - crt_req is forced to 0 that cycle.

Optional Feature:
CRT_UNDERRUN_CNT_EN
- Defined: adds the output port underrun_cnt [15:0], which increments on each underrun pulse, saturates at 16'hFFFF, and is cleared only by hreset (not by line end).
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package crt_buf_pkg holds:
  - the buffer-state enum (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2, DRAINING=2'd3);
  - the buffer-select constants BUF_A=1'b0, BUF_B=1'b1.
- One sub-module, crt_buf_state, instantiated twice. It holds one buffer's state register and takes fill_start, fill_last, pop_first, pop_last and flush as inputs.
- Address counters and select logic stay in the top module.

Test Plan:
- DEPTH=4; reset, then idle 5 cycles -> crt_req=1, a_empty=b_empty=1, no other activity.
- crt_gnt for 1 cycle, then 4 mem_data_valid -> wr_sel=0, wr_addr 0,1,2,3, a_full_done pulses on the 4th write, a_empty stays 0, crt_req returns to 1 (B is empty).
- Fill A then B, then 8 back-to-back crt_pop -> rd_addr 0..3 with rd_sel=0, then 0..3 with rd_sel=1; rd_valid is high for 8 cycles delayed by 1; a_empty rises after pop 4.
- crt_pop while A is FILLING (wr_addr=2) -> underrun=1, rd_addr stays 0; with CRT_UNDERRUN_CNT_EN, underrun_cnt=1.
- sync_crt_line_end mid-fill of B at wr_addr=1 with A DRAINING at rd_addr=2 -> next cycle both empty, all addresses 0, rd_sel=0, no b_full_done after a later mem_data_valid.
- hreset asserted mid-drain -> next cycle all outputs are at their reset values; with the macro, 70000 underruns give underrun_cnt=16'hFFFF.
